// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory request router.
//   - access width codes (MEM_B / MEM_H / MEM_W)
//   - 2-bit FSM state encoding used by mem_router
//   - response data rule: errors and writes return zero read data
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_width_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic [31:0] RESP_ZERO_DATA = 32'h0;

  // Read data presented with mem_ready; errors and writes never leak slave data.
  function automatic logic [31:0] resp_data(input logic        err,
                                            input logic        is_write,
                                            input logic [31:0] rdata);
    return (err || is_write) ? RESP_ZERO_DATA : rdata;
  endfunction

  // Width code 3 is not a defined access size and is not treated as misaligned.
  function automatic logic misaligned(input logic [1:0] width,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (width)
      MEM_B:   bad = 1'b0;
      MEM_H:   bad = addr_lo[0];
      MEM_W:   bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_region_decode.sv
// mem_region_decode: combinational address decoder for mem_router.
// Ports:
//   addr    in  32          byte address to decode
//   hit     out NUM_REGIONS one-hot region hit (lowest index wins on overlap)
//   hit_any out 1           some region contains addr
//   offset  out 32          addr minus base of the winning region (0 on miss)
module mem_region_decode
  import mem_pkg::*;
#(
  parameter int                           NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*32-1:0]    REGION_BASE = {32'h1000, 32'h0},
  parameter logic [NUM_REGIONS*32-1:0]    REGION_SIZE = {32'h1000, 32'h1000}
) (
  input  logic [31:0]            addr,
  output logic [NUM_REGIONS-1:0] hit,
  output logic                   hit_any,
  output logic [31:0]            offset
);

  logic [32:0]            diff [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] in_range;

  // 33-bit subtraction: bit 32 is the borrow, set when addr < base. Once
  // addr >= base, "addr < base + size" is the same as "addr - base < size",
  // which cannot wrap even for regions ending at the top of the address map.
  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_rng
    assign diff[g]     = {1'b0, addr} - {1'b0, REGION_BASE[32*g +: 32]};
    assign in_range[g] = !diff[g][32] && (diff[g][31:0] < REGION_SIZE[32*g +: 32]);
  end

  // Scan from the top so the lowest matching index is the last writer.
  always_comb begin
    hit     = '0;
    hit_any = 1'b0;
    offset  = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (in_range[i]) begin
        hit     = '0;
        hit[i]  = 1'b1;
        hit_any = 1'b1;
        offset  = diff[i][31:0];
      end
    end
  end

endmodule

// File: rtl/mem_router.sv
// mem_router: routes CPU memory requests to NUM_REGIONS memory-mapped slaves.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_addr/mem_width       request address and width (MEM_B/H/W)
//   mem_read_valid           read request
//   mem_write_valid          write request, mem_write_data carries data
//   mem_read_data            read data, valid while mem_ready=1
//   mem_ready / mem_error    one-cycle response strobe / failure qualifier
//   err_addr                 address of the most recent failed access
//   s_addr/s_write_data/s_width  latched, region-relative request to slaves
//   s_read_valid/s_write_valid   one-hot slave request
//   s_read_data/s_ready          slave read data / completion
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a request; decode and latch it
// ST_ISSUE | slave request driven, waiting for s_ready or timeout
// ST_RESP  | mem_ready asserted for one cycle, then back to IDLE
module mem_router
  import mem_pkg::*;
#(
  parameter int                           NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*32-1:0]    REGION_BASE = {32'h1000, 32'h0},
  parameter logic [NUM_REGIONS*32-1:0]    REGION_SIZE = {32'h1000, 32'h1000},
  parameter int                           TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               mem_addr,
  input  logic                      mem_read_valid,
  input  logic                      mem_write_valid,
  input  logic [31:0]               mem_write_data,
  input  logic [1:0]                mem_width,
  output logic [31:0]               mem_read_data,
  output logic                      mem_ready,
  output logic                      mem_error,
  output logic [31:0]               err_addr,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_write_data,
  output logic [1:0]                s_width,
  output logic [NUM_REGIONS-1:0]    s_read_valid,
  output logic [NUM_REGIONS-1:0]    s_write_valid,
  input  logic [NUM_REGIONS*32-1:0] s_read_data,
  input  logic [NUM_REGIONS-1:0]    s_ready
);

  // Counter value seen in the last ISSUE cycle before timing out.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  logic [1:0]             state;
  logic [NUM_REGIONS-1:0] sel;
  logic                   is_write;
  logic [31:0]            lat_addr;
  logic [15:0]            timer;

  logic [NUM_REGIONS-1:0] dec_hit;
  logic                   dec_hit_any;
  logic [31:0]            dec_offset;
  logic                   req;
  logic                   req_err;
  logic                   sel_ready;
  logic [31:0]            sel_data;

  mem_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_SIZE (REGION_SIZE)
  ) u_decode (
    .addr    (mem_addr),
    .hit     (dec_hit),
    .hit_any (dec_hit_any),
    .offset  (dec_offset)
  );

  assign req     = mem_read_valid || mem_write_valid;
  assign req_err = (mem_read_valid && mem_write_valid) || !dec_hit_any ||
                   misaligned(mem_width, mem_addr[1:0]);

  // Completion from any region other than the latched one is ignored.
  assign sel_ready = |(s_ready & sel);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (sel[i]) sel_data = s_read_data[32*i +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      sel           <= '0;
      is_write      <= 1'b0;
      lat_addr      <= '0;
      timer         <= '0;
      mem_ready     <= 1'b0;
      mem_error     <= 1'b0;
      mem_read_data <= '0;
      err_addr      <= '0;
      s_addr        <= '0;
      s_write_data  <= '0;
      s_width       <= '0;
      s_read_valid  <= '0;
      s_write_valid <= '0;
    end else begin
      mem_ready     <= 1'b0;
      mem_error     <= 1'b0;
      mem_read_data <= RESP_ZERO_DATA;
      case (state)
        ST_IDLE: begin
          if (req) begin
            sel          <= dec_hit;
            is_write     <= mem_write_valid;
            lat_addr     <= mem_addr;
            s_addr       <= dec_offset;
            s_write_data <= mem_write_data;
            s_width      <= mem_width;
            timer        <= '0;
            if (req_err) begin
              // Rejected at decode: respond next cycle, never touch a slave.
              state     <= ST_RESP;
              mem_ready <= 1'b1;
              mem_error <= 1'b1;
              err_addr  <= mem_addr;
            end else begin
              state         <= ST_ISSUE;
              s_read_valid  <= mem_read_valid  ? dec_hit : '0;
              s_write_valid <= mem_write_valid ? dec_hit : '0;
            end
          end
        end
        ST_ISSUE: begin
          // A completion in the final allowed cycle still counts as success.
          if (sel_ready) begin
            state         <= ST_RESP;
            mem_ready     <= 1'b1;
            mem_read_data <= resp_data(1'b0, is_write, sel_data);
            s_read_valid  <= '0;
            s_write_valid <= '0;
            timer         <= '0;
          end else if (timer == TIMER_LAST) begin
            state         <= ST_RESP;
            mem_ready     <= 1'b1;
            mem_error     <= 1'b1;
            err_addr      <= lat_addr;
            s_read_valid  <= '0;
            s_write_valid <= '0;
            timer         <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_router.md
# mem_router

Parametrised memory request router between the CPU memory port and NUM_REGIONS memory-mapped slaves (ROM, RAM, peripherals). It is the successor to the fixed two-region ROM/RAM decoder. It decodes each request against per-region base/size parameters and forwards it with a region-relative address. It registers the request, tracks the slave handshake with a timeout, and returns a one-cycle response carrying read data or a bus error. Unmapped, misaligned and timed-out accesses produce errors instead of silently returning zero.

## Interface
- NUM_REGIONS, 2, number of slave regions (1..8)
- REGION_BASE, {32'h1000, 32'h0}, flattened NUM_REGIONS*32 base addresses; region i at bits [32i+31:32i]
- REGION_SIZE, {32'h1000, 32'h1000}, flattened NUM_REGIONS*32 sizes in bytes, each nonzero
- TIMEOUT, 255, maximum ISSUE cycles before a bus error (1..65535)
- clk  in  1  clock; one clock domain
- rst  in  1  reset; synchronous, active-high
- mem_addr  in  32  byte address
- mem_read_valid  in  1  read request
- mem_write_valid  in  1  write request
- mem_write_data  in  32  write data
- mem_width  in  2  MEM_B=0, MEM_H=1, MEM_W=2
- mem_read_data  out  32  read data; valid while mem_ready=1
- mem_ready  out  1  one-cycle response strobe
- mem_error  out  1  qualifies mem_ready: access failed
- err_addr  out  32  address of the most recent failed access (sticky)
- s_addr  out  32  region-relative address (mem_addr - base), shared by all slaves
- s_write_data  out  32  latched write data, shared
- s_width  out  2  latched width, shared
- s_read_valid  out  NUM_REGIONS  one-hot read request
- s_write_valid  out  NUM_REGIONS  one-hot write request
- s_read_data  in  NUM_REGIONS*32  slave read data
- s_ready  in  NUM_REGIONS  slave completion

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE, no valid asserted: stay in IDLE.
- IDLE, exactly one of read/write valid asserted: latch addr, data, width, direction and the region hit.
  - Region i hits when REGION_BASE[i] <= addr < REGION_BASE[i]+REGION_SIZE[i]. The comparison is inclusive at the base and exclusive at the top; use 33-bit arithmetic so the top bound cannot wrap.
  - Overlapping regions: the lowest index wins.
  - Good request (a region hits and the access is aligned): go to ISSUE.
  - Error request: go directly to RESP with the error flagged. Error requests are: no hit; both valids asserted at once; H with addr[0]=1; W with addr[1:0]!=0.
- ISSUE:
  - Drive s_read_valid/s_write_valid for the hit region only, holding the latched values stable.
  - On s_ready[hit]: capture s_read_data[hit] (reads only) and go to RESP.
  - Timeout counter starts at 0 on entry and increments each ISSUE cycle. When it reaches TIMEOUT without s_ready, go to RESP with the error flagged; the slave valid drops in RESP.
- RESP:
  - mem_ready=1 for exactly one cycle.
  - mem_error=1 and mem_read_data=0 on error.
  - mem_read_data=0 for writes.
  - On error, err_addr is loaded with the latched address.
  - Always returns to IDLE.
- The master holds its request stable until it sees mem_ready, then deasserts. Any valid seen in IDLE is a new request.
- s_ready for a non-hit region and s_ready outside ISSUE are ignored.

## Timing
- Reset values: state IDLE, mem_ready 0, mem_error 0, mem_read_data 0, err_addr 0, all s_*_valid 0, s_addr/s_write_data/s_width 0, timeout counter 0.
- Good access:
  - Request sampled at edge 0.
  - s_*_valid high from cycle 1.
  - s_ready in cycle k (k>=1) gives mem_ready in cycle k+1.
  - Minimum latency is 2 cycles.
- Error at decode: mem_ready in cycle 1; no slave valid is ever asserted.
- Timeout: s_*_valid high for exactly TIMEOUT cycles (cycles 1..TIMEOUT); mem_ready+mem_error in cycle TIMEOUT+1.
- Back-to-back: a new request can be accepted in the IDLE cycle after RESP, so the throughput is one access per 3 cycles.
- rst asserted in any state: all outputs take their reset values at the next edge. An in-flight slave request is abandoned and no response is issued.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package mem_pkg holds:
  - MEM_B/MEM_H/MEM_W width codes
  - the FSM state encoding (2 bits)
  - the RESP data-zeroing rule constant
- Sub-module mem_region_decode: a combinational block, parameterised identically. It takes the address and outputs a one-hot hit vector, a hit_any flag, and the relative offset. It is instantiated once inside mem_router.

## Test plan
- Default params; word read at 0x1004; RAM slave ready in its first ISSUE cycle with data 0xDEADBEEF -> s_addr=0x004, s_read_valid=2'b10 in cycle 1, mem_ready with data 0xDEADBEEF in cycle 2, mem_error=0.
- Reads at boundary addresses 0x0FFF (B), 0x1000 (B) and 0x2000 (B) -> regions 0 and 1 are hit with offsets 0xFFF and 0x000; 0x2000 gives mem_error=1 in cycle 1, err_addr=0x2000, no slave valid.
- Misaligned requests: W write at 0x1002, and H read at 0x0001 -> error response in cycle 1, s_write_valid never set.
- TIMEOUT=4, slave never ready -> s_read_valid high for 4 cycles, then mem_ready=1, mem_error=1, mem_read_data=0.
- mem_read_valid and mem_write_valid both high -> immediate error; rst pulsed in the second ISSUE cycle -> all valids 0 next cycle, no mem_ready.
- Three back-to-back writes of 0x11/0x22/0x33 to 0x1000/0x1004/0x0FFC (the ROM region accepts writes in the bench model) -> three responses, each 3 cycles apart, with the correct one-hot region selection.
